// File: rtl/tag_stream_if.sv
// AXI-Stream tag bus carrying WORD_WIDTH tag lanes per beat plus the beat's lowest time bound.
// Handshake: a beat transfers on every clock edge where tvalid && tready; once tvalid is high the master holds tkeep/tagtime/channel/lowest_time_bound stable until that transfer, tvalid never waits on tready, and tready may stay low indefinitely.
interface tag_stream_if #(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6
) ();
  logic                               tvalid;
  logic                               tready;
  logic [WORD_WIDTH-1:0]              tkeep;
  logic [WORD_WIDTH*TIME_WIDTH-1:0]   tagtime;
  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] channel;
  logic [TIME_WIDTH-1:0]              lowest_time_bound;

  modport master (
    output tvalid, tkeep, tagtime, channel, lowest_time_bound,
    input  tready
  );

  modport slave (
    input  tvalid, tkeep, tagtime, channel, lowest_time_bound,
    output tready
  );
endinterface

// File: rtl/tag_stream_generator.sv
// Synthetic tag source: emits a programmed number of evenly spaced tags with rotating
// channels as an AXI-Stream tag stream, for loopback self-test of the measurement paths.
module tag_stream_generator #(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6,
  parameter int COUNT_WIDTH   = 32,
  localparam int NW = $clog2(WORD_WIDTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic                     abort_i,
  input  logic [TIME_WIDTH-1:0]    t0_i,
  input  logic [TIME_WIDTH-1:0]    period_i,
  input  logic [CHANNEL_WIDTH-1:0] chan_first_i,
  input  logic [CHANNEL_WIDTH-1:0] chan_count_i,
  input  logic [COUNT_WIDTH-1:0]   num_tags_i,
  input  logic [NW-1:0]            tags_per_beat_i,
  tag_stream_if.master             m_axis,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [COUNT_WIDTH-1:0]   tags_sent_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state;

  logic [TIME_WIDTH-1:0]    cfg_period;
  logic [CHANNEL_WIDTH-1:0] cfg_first;
  logic [CHANNEL_WIDTH-1:0] cfg_last_idx;
  logic [NW-1:0]            cfg_tpb;

  // nxt_* describe the beat that has not been presented yet.
  logic [TIME_WIDTH-1:0]    nxt_base;
  logic [CHANNEL_WIDTH-1:0] nxt_rot;
  logic [COUNT_WIDTH-1:0]   nxt_rem;
  logic [NW-1:0]            cur_n;
  logic                     abort_pend;

  logic [TIME_WIDTH-1:0]    lane_off [WORD_WIDTH+1];
  logic [CHANNEL_WIDTH-1:0] lane_idx [WORD_WIDTH+1];
  logic [NW-1:0]                       beat_n;
  logic [WORD_WIDTH-1:0]               beat_keep;
  logic [WORD_WIDTH*TIME_WIDTH-1:0]    beat_time;
  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] beat_chan;
  logic [TIME_WIDTH-1:0]               beat_adv;
  logic [CHANNEL_WIDTH-1:0]            beat_rot;

  logic handshake;
  logic finish;
  logic present;

  assign state_o = state;

  // Lane offsets are an add chain of the period; the rotation index wraps via compare, no divider.
  always_comb begin
    lane_off[0] = '0;
    lane_idx[0] = nxt_rot;
    for (int i = 1; i <= WORD_WIDTH; i++) begin
      lane_off[i] = lane_off[i-1] + cfg_period;
      lane_idx[i] = (lane_idx[i-1] == cfg_last_idx) ? '0
                                                    : lane_idx[i-1] + CHANNEL_WIDTH'(1);
    end
    beat_n    = (nxt_rem < COUNT_WIDTH'(cfg_tpb)) ? NW'(nxt_rem) : cfg_tpb;
    beat_keep = '0;
    beat_time = '0;
    beat_chan = '0;
    beat_adv  = '0;
    beat_rot  = nxt_rot;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (NW'(i) < beat_n) begin
        beat_keep[i]                                = 1'b1;
        beat_time[i*TIME_WIDTH +: TIME_WIDTH]       = nxt_base + lane_off[i];
        beat_chan[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] = cfg_first + lane_idx[i];
      end
    end
    for (int i = 0; i <= WORD_WIDTH; i++) begin
      if (NW'(i) == beat_n) begin
        beat_adv = lane_off[i];
        beat_rot = lane_idx[i];
      end
    end
  end

  assign handshake = m_axis.tvalid && m_axis.tready;
  assign finish    = (state == ST_RUN) && handshake &&
                     ((nxt_rem == '0) || abort_pend || abort_i);
  assign present   = ((state == ST_LOAD) && (nxt_rem != '0)) ||
                     ((state == ST_RUN) && handshake && !finish);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                    <= ST_IDLE;
      m_axis.tvalid            <= 1'b0;
      m_axis.tkeep             <= '0;
      m_axis.tagtime           <= '0;
      m_axis.channel           <= '0;
      m_axis.lowest_time_bound <= '0;
      busy_o                   <= 1'b0;
      done_o                   <= 1'b0;
      tags_sent_o              <= '0;
      cfg_period               <= '0;
      cfg_first                <= '0;
      cfg_last_idx             <= '0;
      cfg_tpb                  <= '0;
      nxt_base                 <= '0;
      nxt_rot                  <= '0;
      nxt_rem                  <= '0;
      cur_n                    <= '0;
      abort_pend               <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if ((state == ST_RUN) && abort_i) abort_pend <= 1'b1;
      if ((state == ST_RUN) && handshake) tags_sent_o <= tags_sent_o + COUNT_WIDTH'(cur_n);

      case (state)
        ST_IDLE: begin
          if (start_i) begin
            cfg_period   <= period_i;
            cfg_first    <= chan_first_i;
            cfg_last_idx <= (chan_count_i == '0) ? '0 : chan_count_i - CHANNEL_WIDTH'(1);
            cfg_tpb      <= ((tags_per_beat_i == '0) || (tags_per_beat_i > NW'(WORD_WIDTH)))
                            ? NW'(WORD_WIDTH) : tags_per_beat_i;
            nxt_base     <= t0_i;
            nxt_rot      <= '0;
            nxt_rem      <= num_tags_i;
            tags_sent_o  <= '0;
            abort_pend   <= 1'b0;
            busy_o       <= 1'b1;
            state        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (nxt_rem == '0) begin
            busy_o <= 1'b0;
            done_o <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (finish) begin
            m_axis.tvalid            <= 1'b0;
            m_axis.tkeep             <= '0;
            m_axis.tagtime           <= '0;
            m_axis.channel           <= '0;
            m_axis.lowest_time_bound <= '0;
            busy_o                   <= 1'b0;
            done_o                   <= 1'b1;
            state                    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (present) begin
        m_axis.tvalid            <= 1'b1;
        m_axis.tkeep             <= beat_keep;
        m_axis.tagtime           <= beat_time;
        m_axis.channel           <= beat_chan;
        m_axis.lowest_time_bound <= nxt_base;
        cur_n                    <= beat_n;
        nxt_base                 <= nxt_base + beat_adv;
        nxt_rot                  <= beat_rot;
        nxt_rem                  <= nxt_rem - COUNT_WIDTH'(beat_n);
      end
    end
  end

endmodule

// File: tb/tb_tag_stream_generator.sv
// Self-checking bench for tag_stream_generator: tag lists are derived from t0 + j*period and
// first + (j mod count), chunked into beats, and compared against every accepted beat.
module tb_tag_stream_generator;
  localparam int WW = 4;
  localparam int TW = 64;
  localparam int CW = 6;
  localparam int NC = 32;
  localparam int NW = 3;
  localparam int BW = WW + WW*TW + WW*CW + TW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [TW-1:0] t0_i = '0;
  logic [TW-1:0] period_i = '0;
  logic [CW-1:0] chan_first_i = '0;
  logic [CW-1:0] chan_count_i = '0;
  logic [NC-1:0] num_tags_i = '0;
  logic [NW-1:0] tags_per_beat_i = '0;
  logic          busy_o;
  logic          done_o;
  logic [NC-1:0] tags_sent_o;
  logic [1:0]    state_o;

  tag_stream_if #(.WORD_WIDTH(WW), .TIME_WIDTH(TW), .CHANNEL_WIDTH(CW)) m_axis ();

  tag_stream_generator #(
    .WORD_WIDTH(WW), .TIME_WIDTH(TW), .CHANNEL_WIDTH(CW), .COUNT_WIDTH(NC)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .t0_i(t0_i), .period_i(period_i), .chan_first_i(chan_first_i),
    .chan_count_i(chan_count_i), .num_tags_i(num_tags_i),
    .tags_per_beat_i(tags_per_beat_i), .m_axis(m_axis),
    .busy_o(busy_o), .done_o(done_o), .tags_sent_o(tags_sent_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] got_q[$];
  int first_valid, done_cyc, last_acc, done_pulses, stall_viol, valid_after;
  logic [BW-1:0] cur_beat;

  assign cur_beat = {m_axis.tkeep, m_axis.tagtime, m_axis.channel, m_axis.lowest_time_bound};

  // Expected beats straight from the tag list definition.
  task automatic build_model(input logic [TW-1:0] t0, input logic [TW-1:0] period,
                             input logic [CW-1:0] first, input logic [CW-1:0] cnt,
                             input int num, input logic [NW-1:0] tpb);
    int per, cnte;
    logic [WW-1:0]    keep;
    logic [WW*TW-1:0] times;
    logic [WW*CW-1:0] chans;
    logic [TW-1:0]    bound;
    per  = (tpb == 0 || int'(tpb) > WW) ? WW : int'(tpb);
    cnte = (cnt == 0) ? 1 : int'(cnt);
    exp_q.delete();
    for (int b = 0; b * per < num; b++) begin
      keep = '0; times = '0; chans = '0;
      for (int i = 0; i < per; i++) begin
        if (b * per + i < num) begin
          keep[i]            = 1'b1;
          times[i*TW +: TW]  = t0 + TW'(b * per + i) * period;
          chans[i*CW +: CW]  = first + CW'((b * per + i) % cnte);
        end
      end
      bound = t0 + TW'(b * per) * period;
      exp_q.push_back({keep, times, chans, bound});
    end
  endtask

  // Starts a run and records every accepted beat, stall stability and timing of done.
  task automatic drive_run(input logic [TW-1:0] t0, input logic [TW-1:0] period,
                           input logic [CW-1:0] first, input logic [CW-1:0] cnt,
                           input logic [NC-1:0] num, input logic [NW-1:0] tpb,
                           input bit rnd, input int abort_beat);
    logic [BW-1:0] prev;
    bit stalled, abort_done;
    int c;
    got_q.delete();
    first_valid = -1; done_cyc = -1; last_acc = -1; done_pulses = 0;
    stall_viol = 0; valid_after = 0; stalled = 0; abort_done = 0; prev = '0;
    t0_i = t0; period_i = period; chan_first_i = first; chan_count_i = cnt;
    num_tags_i = num; tags_per_beat_i = tpb; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    c = 0;
    while (c < 400 && done_cyc < 0) begin
      t0_i = {$urandom, $urandom}; period_i = {$urandom, $urandom};
      chan_first_i = CW'($urandom); chan_count_i = CW'($urandom);
      num_tags_i = $urandom; tags_per_beat_i = NW'($urandom);
      if (m_axis.tvalid && first_valid < 0) first_valid = c;
      if (stalled && (!m_axis.tvalid || cur_beat !== prev)) stall_viol++;
      if (done_o) begin done_cyc = c; done_pulses++; end
      start_i = (rnd && done_cyc < 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      m_axis.tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      abort_i = 1'b0;
      if (abort_beat >= 0 && !abort_done && m_axis.tvalid && got_q.size() == abort_beat) begin
        m_axis.tready = 1'b0; abort_i = 1'b1; abort_done = 1;
      end
      if (m_axis.tvalid && m_axis.tready) begin got_q.push_back(cur_beat); last_acc = c; end
      stalled = m_axis.tvalid && !m_axis.tready;
      prev = cur_beat;
      @(negedge clk);
      c++;
    end
    start_i = 1'b0; abort_i = 1'b0; m_axis.tready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (m_axis.tvalid) valid_after++;
      if (done_o) done_pulses++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b1; m_axis.tready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_axis.tvalid, m_axis.tkeep, busy_o, done_o} !== '0) begin
      errors++; $display("FAIL reset_ctrl: tvalid/tkeep/busy/done=%b expected 0",
                         {m_axis.tvalid, m_axis.tkeep, busy_o, done_o});
    end
    checks++;
    if (cur_beat !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", cur_beat); end
    checks++;
    if (tags_sent_o !== '0 || state_o !== 2'd0) begin
      errors++; $display("FAIL reset_count: tags_sent=%0d state=%0d expected 0/0", tags_sent_o, state_o);
    end
    start_i = 1'b0; rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [BW-1:0] bt;
    build_model(64'd1000, 64'd10, 6'd2, 6'd3, 8, 3'd4);
    drive_run(64'd1000, 64'd10, 6'd2, 6'd3, 32'd8, 3'd4, 1'b0, -1);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL basic_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[b]) if (b < got_q.size()) begin
      checks++;
      if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL basic_beat%0d: got %h expected %h", b, got_q[b], exp_q[b]); end
    end
    bt = (got_q.size() >= 2) ? got_q[1] : '0;
    checks++;
    if (bt[TW-1:0] !== 64'd1040 || bt[TW+WW*CW+3*TW +: TW] !== 64'd1070 || bt[TW +: WW*CW] !== {6'd3, 6'd2, 6'd4, 6'd3}) begin
      errors++; $display("FAIL basic_beat1_fields: got %h expected bound 1040 lane3 1070 ch 3,4,2,3", bt);
    end
    checks++;
    if (first_valid !== 1) begin errors++; $display("FAIL basic_latency: got %0d expected 1", first_valid); end
    checks++;
    if (done_cyc !== last_acc + 1 || done_pulses !== 1) begin
      errors++; $display("FAIL basic_done: done at %0d pulses %0d, expected at %0d pulses 1", done_cyc, done_pulses, last_acc + 1);
    end
    checks++;
    if (tags_sent_o !== 32'd8 || busy_o !== 1'b0 || valid_after !== 0) begin
      errors++; $display("FAIL basic_end: tags_sent=%0d busy=%b valid_after=%0d expected 8/0/0", tags_sent_o, busy_o, valid_after);
    end
  endtask

  task automatic test_partial;
    logic [BW-1:0] bt;
    build_model(64'd500, 64'd7, 6'd0, 6'd4, 6, 3'd4);
    drive_run(64'd500, 64'd7, 6'd0, 6'd4, 32'd6, 3'd4, 1'b0, -1);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL partial_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[b]) if (b < got_q.size()) begin
      checks++;
      if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL partial_beat%0d: got %h expected %h", b, got_q[b], exp_q[b]); end
    end
    bt = (got_q.size() >= 2) ? got_q[1] : '0;
    checks++;
    if (bt[BW-1 -: WW] !== 4'b0011 || bt[TW+WW*CW+2*TW +: 2*TW] !== '0 || bt[TW+2*CW +: 2*CW] !== '0) begin
      errors++; $display("FAIL partial_tail: got %h expected keep 0011 with zero lanes 2-3", bt);
    end
    checks++;
    if (tags_sent_o !== 32'd6) begin errors++; $display("FAIL partial_sent: got %0d expected 6", tags_sent_o); end
  endtask

  task automatic test_backpressure;
    build_model(64'd1000, 64'd10, 6'd2, 6'd3, 8, 3'd4);
    drive_run(64'd1000, 64'd10, 6'd2, 6'd3, 32'd8, 3'd4, 1'b1, -1);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++; $display("FAIL bp_count: got %0d beats expected %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[b]) if (b < got_q.size()) begin
      checks++;
      if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL bp_beat%0d: got %h expected %h", b, got_q[b], exp_q[b]); end
    end
    checks++;
    if (stall_viol !== 0) begin errors++; $display("FAIL bp_stable: %0d unstable stall cycles, expected 0", stall_viol); end
    checks++;
    if (tags_sent_o !== 32'd8 || done_cyc !== last_acc + 1) begin
      errors++; $display("FAIL bp_end: tags_sent=%0d done=%0d expected 8 done=%0d", tags_sent_o, done_cyc, last_acc + 1);
    end
  endtask

  task automatic test_wrap;
    logic [TW-1:0] t0;
    logic [BW-1:0] bt;
    t0 = 64'hFFFF_FFFF_FFFF_FFF1;
    build_model(t0, 64'd10, 6'd5, 6'd2, 3, 3'd4);
    drive_run(t0, 64'd10, 6'd5, 6'd2, 32'd3, 3'd4, 1'b0, -1);
    bt = (got_q.size() >= 1) ? got_q[0] : '0;
    checks++;
    if (got_q.size() !== 1 || bt !== exp_q[0]) begin
      errors++; $display("FAIL wrap_beat: got %0d beats, beat0 %h expected %h", got_q.size(), bt, exp_q[0]);
    end
    checks++;
    if (bt[TW+WW*CW+2*TW +: TW] !== 64'd5 || bt[TW+WW*CW+TW +: TW] !== 64'hFFFF_FFFF_FFFF_FFFB) begin
      errors++; $display("FAIL wrap_times: lane1 %h lane2 %h expected fffffffffffffffb/5",
                         bt[TW+WW*CW+TW +: TW], bt[TW+WW*CW+2*TW +: TW]);
    end
  endtask

  task automatic test_abort;
    build_model(64'd0, 64'd3, 6'd1, 6'd5, 100, 3'd4);
    while (exp_q.size() > 3) exp_q.pop_back();
    drive_run(64'd0, 64'd3, 6'd1, 6'd5, 32'd100, 3'd4, 1'b0, 2);
    checks++;
    if (got_q.size() !== 3) begin errors++; $display("FAIL abort_count: got %0d beats expected 3", got_q.size()); end
    foreach (exp_q[b]) if (b < got_q.size()) begin
      checks++;
      if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL abort_beat%0d: got %h expected %h", b, got_q[b], exp_q[b]); end
    end
    checks++;
    if (tags_sent_o !== 32'd12 || done_pulses !== 1 || valid_after !== 0) begin
      errors++; $display("FAIL abort_end: tags_sent=%0d pulses=%0d valid_after=%0d expected 12/1/0", tags_sent_o, done_pulses, valid_after);
    end
  endtask

  task automatic test_reset_midrun;
    t0_i = 64'd0; period_i = 64'd1; chan_first_i = 6'd0; chan_count_i = 6'd1;
    num_tags_i = 32'd20; tags_per_beat_i = 3'd4; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; m_axis.tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (tags_sent_o !== 32'd4 || m_axis.tvalid !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: tags_sent=%0d tvalid=%b expected 4/1", tags_sent_o, m_axis.tvalid);
    end
    m_axis.tready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (m_axis.tvalid !== 1'b0 || busy_o !== 1'b0 || tags_sent_o !== '0 || cur_beat !== '0) begin
      errors++; $display("FAIL midrun_reset: tvalid=%b busy=%b tags_sent=%0d expected 0/0/0",
                         m_axis.tvalid, busy_o, tags_sent_o);
    end
    drive_run(64'd9, 64'd9, 6'd0, 6'd0, 32'd0, 3'd4, 1'b0, -1);
    checks++;
    if (done_cyc !== 1 || first_valid !== -1 || got_q.size() !== 0 || valid_after !== 0) begin
      errors++; $display("FAIL zero_tags: done at %0d first_valid %0d beats %0d expected 1/-1/0",
                         done_cyc, first_valid, got_q.size());
    end
  endtask

  task automatic test_random;
    logic [TW-1:0] t0, period;
    logic [CW-1:0] first, cnt;
    logic [NW-1:0] tpb;
    int num;
    for (int r = 0; r < 8; r++) begin
      t0 = {$urandom, $urandom};
      period = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
      first = CW'($urandom); cnt = CW'($urandom_range(0, 9)); tpb = NW'($urandom);
      num = $urandom_range(1, 40);
      build_model(t0, period, first, cnt, num, tpb);
      drive_run(t0, period, first, cnt, NC'(num), tpb, 1'b1, -1);
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d beats expected %0d", r, got_q.size(), exp_q.size());
      end
      foreach (exp_q[b]) if (b < got_q.size()) begin
        checks++;
        if (got_q[b] !== exp_q[b]) begin errors++; $display("FAIL rand%0d_beat%0d: got %h expected %h", r, b, got_q[b], exp_q[b]); end
      end
      checks++;
      if (tags_sent_o !== NC'(num) || stall_viol !== 0 || done_pulses !== 1) begin
        errors++; $display("FAIL rand%0d_end: tags_sent=%0d stall_viol=%0d pulses=%0d expected %0d/0/1",
                           r, tags_sent_o, stall_viol, done_pulses, num);
      end
    end
  endtask

  initial begin
    m_axis.tready = 1'b0;
    test_reset;
    test_basic;
    test_partial;
    test_backpressure;
    test_wrap;
    test_abort;
    test_reset_midrun;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tag_stream_generator.md
Name: tag_stream_generator

Overview:
- Synthetic tag source: drives an AXI-Stream tag stream (tvalid/tready/tkeep, per-lane tagtime and channel, lowest_time_bound) of the same shape the measurement consumers accept.
- Sits in front of measurement for on-FPGA loopback/self-test of the histogram and counter paths without an external Time Tagger.
- Emits a programmed number of tags at a fixed time spacing, with channels rotating over a programmed range, under full backpressure.

Parameters:
- WORD_WIDTH, 4: tag lanes per beat.
- TIME_WIDTH, 64: tagtime width; arithmetic is modulo 2^TIME_WIDTH.
- CHANNEL_WIDTH, 6: channel field width.
- COUNT_WIDTH, 32: width of the tag-count configuration.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle pulse; latches config and starts a run (ignored unless IDLE).
- abort_i  in  1  stop after the currently presented beat is accepted.
- t0_i  in  TIME_WIDTH  time of the first tag.
- period_i  in  TIME_WIDTH  spacing between consecutive tags; 0 is legal (all tags equal).
- chan_first_i  in  CHANNEL_WIDTH  first channel of the rotation.
- chan_count_i  in  CHANNEL_WIDTH  rotation length; 0 is treated as 1.
- num_tags_i  in  COUNT_WIDTH  tags per run; 0 means the run completes with no beats.
- tags_per_beat_i  in  clog2(WORD_WIDTH+1)  valid lanes per full beat; 0 and values >WORD_WIDTH are clamped to WORD_WIDTH.
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tkeep  out  WORD_WIDTH  contiguous from lane 0.
- m_axis_tagtime  out  WORD_WIDTH*TIME_WIDTH  lane i at [i*TIME_WIDTH +: TIME_WIDTH].
- m_axis_channel  out  WORD_WIDTH*CHANNEL_WIDTH  lane i at [i*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- m_axis_lowest_time_bound  out  TIME_WIDTH  tagtime of lane 0 of the current beat.
- busy_o  out  1  high in LOAD and RUN.
- done_o  out  1  one-cycle pulse on completion or abort.
- tags_sent_o  out  COUNT_WIDTH  tags accepted (tkeep lanes) in the current/last run.

Behaviour:
- Reset: all outputs 0 (tvalid, tkeep, tagtime, channel, bound, busy, done, tags_sent); state IDLE. Reset mid-run drops the beat in flight immediately.
- States:
  - IDLE: on start_i, latch all config, clear tags_sent, go to LOAD.
  - LOAD: compute the first beat (one cycle), go to RUN. If num_tags = 0, go straight to IDLE with a done pulse and no beat.
  - RUN: tvalid = 1 with the beat registered. On a tvalid & tready cycle:
    - add popcount(tkeep) to tags_sent.
    - if remaining = 0 or abort is pending, drop tvalid next cycle, pulse done, go to IDLE.
    - otherwise present the next beat in the following cycle with no bubble.
- Beat contents: n = min(tags_per_beat, remaining). Lanes 0..n-1 kept; remaining lanes have tkeep = 0 with tagtime/channel = 0.
  - Lane i tagtime = base + i*period, where base = t0 + k*period and k = tags already emitted.
  - Channel = chan_first + ((k+i) mod chan_count), truncated to CHANNEL_WIDTH.
- Handshake: AXIS rules. Once tvalid is high, tkeep, tagtime, channel and bound hold stable until accepted. tvalid never depends on tready. tready low for any number of cycles stalls without loss.
- Abort: abort_i is sampled in RUN and stored as pending. The current beat completes normally, then the block goes to IDLE. Abort in IDLE/LOAD is ignored.
- start_i while busy is ignored. Config inputs may change freely after the start_i cycle.
- Throughput: one beat per cycle under continuous tready. Latency from start_i to first tvalid is 2 cycles.
- Arithmetic:
  - tagtime wraps modulo 2^TIME_WIDTH.
  - period multiply per lane is i*period with i < WORD_WIDTH, done as a shift/add tree or registered increment.
  - The channel rotation index is kept as a counter (no divider).

Test Plan:
- t0=1000, period=10, chan_first=2, chan_count=3, num_tags=8, tpb=4, tready=1 -> beat0 times 1000/1010/1020/1030, ch 2,3,4,2; beat1 times 1040..1070, ch 3,4,2,3; bound 1000 then 1040; done 1 cycle after beat1 accepted; tags_sent=8.
- num_tags=6, tpb=4 -> beat1 tkeep=4'b0011, lanes 2-3 zero; tags_sent=6.
- Same as the first scenario with tready toggling 1-0-0-1 randomly -> identical accepted sequence; tvalid/data stable across stalls.
- t0=2^64-15, period=10, num_tags=3, tpb=4 -> times 2^64-15, 2^64-5, 5 (wrap).
- num_tags=100, abort_i asserted while beat 2 stalled -> beat 2 accepted, no beat 3, done pulse, tags_sent=12.
- rst during RUN with tvalid high -> next cycle tvalid=0, busy=0, tags_sent=0; new start_i works; num_tags=0 -> done 2 cycles after start, no tvalid.
